// File: rtl/g9_multicycle_sequencer.sv
// G9 multi-cycle control sequencer: steps FETCH/DECODE/EXEC/MEM/WB and emits registered datapath enables.
// Optional performance counters are built only when G9_SEQ_PERF_EN is defined.
module g9_multicycle_sequencer #(
    parameter int size     = 32,
    parameter int IMEM_LAT = 1,
    parameter int DMEM_LAT = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    input  logic            halt_req,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic            reg_write,
    input  logic            call,
    output logic            ir_en,
    output logic            alu_en,
    output logic            dmem_re,
    output logic            dmem_we,
    output logic            rf_we,
    output logic            pc_en,
    output logic [2:0]      state,
    output logic            busy,
    output logic            halted,
    output logic [size-1:0] cycle_count,
    output logic [size-1:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    typedef struct packed {
        logic ir;
        logic alu;
        logic dre;
        logic dwe;
        logic rfwe;
        logic pc;
        logic busy;
        logic halted;
    } outs_t;

    localparam logic [2:0] IMEM_LAST = 3'(IMEM_LAT - 1);
    localparam logic [2:0] DMEM_LAST = 3'(DMEM_LAT - 1);

    state_t     state_q, state_d, commit_state_s;
    logic [2:0] cnt_q, cnt_d;
    logic       rd_q, rd_d, wr_q, wr_d, wb_q, wb_d;
    outs_t      outs_q, outs_d;

    // Enables are a pure decode of (state, wait count, latched flags); evaluated on next-state values so they can be flopped.
    function automatic outs_t decode_outs(input state_t st, input logic [2:0] cnt,
                                          input logic rd, input logic wr, input logic wb);
        outs_t o;
        o = '0;
        case (st)
            S_FETCH: begin
                o.ir   = (cnt == IMEM_LAST);
                o.busy = 1'b1;
            end
            S_DECODE: o.busy = 1'b1;
            S_EXEC: begin
                o.alu  = 1'b1;
                o.pc   = ~(rd | wr | wb);
                o.busy = 1'b1;
            end
            S_MEM: begin
                o.dre  = rd;
                o.dwe  = wr & (cnt == 3'd0);
                o.pc   = ~rd & (cnt == DMEM_LAST);
                o.busy = 1'b1;
            end
            S_WB: begin
                o.rfwe = 1'b1;
                o.pc   = 1'b1;
                o.busy = 1'b1;
            end
            S_HALT:  o.halted = 1'b1;
            default: o = '0;
        endcase
        return o;
    endfunction

    // Next-state, wait counter, flag latching and next-cycle output decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        wb_d    = wb_q;
        if (halt_req) begin
            commit_state_s = S_HALT;
        end else if (run) begin
            commit_state_s = S_FETCH;
        end else begin
            commit_state_s = S_IDLE;
        end
        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_IDLE;
                end
                cnt_d = 3'd0;
            end
            S_FETCH: begin
                if (cnt_q == IMEM_LAST) begin
                    state_d = S_DECODE;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_DECODE: begin
                rd_d    = mem_read;
                wr_d    = mem_write;
                wb_d    = reg_write | call;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (rd_q | wr_q) begin
                    state_d = S_MEM;
                    cnt_d   = 3'd0;
                end else if (wb_q) begin
                    state_d = S_WB;
                end else begin
                    state_d = commit_state_s;
                end
            end
            S_MEM: begin
                if (cnt_q == DMEM_LAST) begin
                    cnt_d = 3'd0;
                    if (rd_q) begin
                        state_d = S_WB;
                    end else begin
                        state_d = commit_state_s;
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_WB:    state_d = commit_state_s;
            S_HALT:  state_d = S_HALT;
            default: begin
                state_d = S_IDLE;
                cnt_d   = 3'd0;
            end
        endcase
        outs_d = decode_outs(state_d, cnt_d, rd_d, wr_d, wb_d);
    end

    // Sequencer state and registered enables; reset abandons any in-flight instruction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            wb_q    <= 1'b0;
            outs_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            wb_q    <= wb_d;
            outs_q  <= outs_d;
        end
    end

    assign state   = state_q;
    assign ir_en   = outs_q.ir;
    assign alu_en  = outs_q.alu;
    assign dmem_re = outs_q.dre;
    assign dmem_we = outs_q.dwe;
    assign rf_we   = outs_q.rfwe;
    assign pc_en   = outs_q.pc;
    assign busy    = outs_q.busy;
    assign halted  = outs_q.halted;

`ifdef G9_SEQ_PERF_EN
    logic [size-1:0] cycle_count_q, cycle_count_d;
    logic [size-1:0] instr_count_q, instr_count_d;

    // Counters advance on the registered busy and pc_en of the cycle just ending.
    always_comb begin
        cycle_count_d = cycle_count_q + {{(size-1){1'b0}}, outs_q.busy};
        instr_count_d = instr_count_q + {{(size-1){1'b0}}, outs_q.pc};
    end

    // Performance counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_count_q <= '0;
            instr_count_q <= '0;
        end else begin
            cycle_count_q <= cycle_count_d;
            instr_count_q <= instr_count_d;
        end
    end

    assign cycle_count = cycle_count_q;
    assign instr_count = instr_count_q;
`else
    assign cycle_count = '0;
    assign instr_count = '0;
`endif

endmodule

// File: tb/tb_g9_multicycle_sequencer.sv
// Bench for g9_multicycle_sequencer: two latency configurations checked cycle by cycle against
// per-instruction expected timelines built from the instruction class.
`timescale 1ns/1ps
module tb_g9_multicycle_sequencer;

    localparam int SZ  = 32;
    localparam int LI0 = 1;
    localparam int LD0 = 2;
    localparam int LI1 = 2;
    localparam int LD1 = 3;

    typedef struct packed {
        logic [2:0] st;
        logic       ir;
        logic       alu;
        logic       re;
        logic       we;
        logic       rf;
        logic       pc;
    } rec_t;

    logic clk = 1'b0;
    logic reset;
    logic run_i[2], halt_i[2], rd_i[2], wr_i[2], rg_i[2], cl_i[2];
    logic ir_o[2], alu_o[2], re_o[2], we_o[2], rf_o[2], pc_o[2], busy_o[2], halted_o[2];
    logic [2:0]    st_o[2];
    logic [SZ-1:0] cyc_o[2], ins_o[2];

    int   vectors     = 0;
    int   miscompares = 0;
    int   model_cyc[2];
    int   model_ins[2];
    rec_t trace[$];

    always #5 clk = ~clk;

    g9_multicycle_sequencer #(.size(SZ), .IMEM_LAT(LI0), .DMEM_LAT(LD0)) dut_a (
        .clk(clk), .reset(reset), .run(run_i[0]), .halt_req(halt_i[0]),
        .mem_read(rd_i[0]), .mem_write(wr_i[0]), .reg_write(rg_i[0]), .call(cl_i[0]),
        .ir_en(ir_o[0]), .alu_en(alu_o[0]), .dmem_re(re_o[0]), .dmem_we(we_o[0]),
        .rf_we(rf_o[0]), .pc_en(pc_o[0]), .state(st_o[0]), .busy(busy_o[0]),
        .halted(halted_o[0]), .cycle_count(cyc_o[0]), .instr_count(ins_o[0])
    );

    g9_multicycle_sequencer #(.size(SZ), .IMEM_LAT(LI1), .DMEM_LAT(LD1)) dut_b (
        .clk(clk), .reset(reset), .run(run_i[1]), .halt_req(halt_i[1]),
        .mem_read(rd_i[1]), .mem_write(wr_i[1]), .reg_write(rg_i[1]), .call(cl_i[1]),
        .ir_en(ir_o[1]), .alu_en(alu_o[1]), .dmem_re(re_o[1]), .dmem_we(we_o[1]),
        .rf_we(rf_o[1]), .pc_en(pc_o[1]), .state(st_o[1]), .busy(busy_o[1]),
        .halted(halted_o[1]), .cycle_count(cyc_o[1]), .instr_count(ins_o[1])
    );

    function automatic int li(input int d);
        return (d == 0) ? LI0 : LI1;
    endfunction

    function automatic int ld(input int d);
        return (d == 0) ? LD0 : LD1;
    endfunction

    function automatic logic [10:0] obs_vec(input int d);
        return {st_o[d], ir_o[d], alu_o[d], re_o[d], we_o[d], rf_o[d], pc_o[d], busy_o[d], halted_o[d]};
    endfunction

    function automatic logic [10:0] exp_vec(input rec_t r);
        logic b, h;
        b = (r.st >= 3'd1) && (r.st <= 3'd5);
        h = (r.st == 3'd6);
        return {r, b, h};
    endfunction

    function automatic logic [SZ-1:0] exp_cnt(input int v);
`ifdef G9_SEQ_PERF_EN
        return SZ'(v);
`else
        return (v == 0) ? '0 : '0;
`endif
    endfunction

    // Timeline of one instruction: L_I fetch cycles, decode, execute, optional memory phase, optional write-back.
    task automatic build_trace(input int d, input bit rd, input bit wr, input bit wb);
        rec_t r;
        trace.delete();
        for (int i = 0; i < li(d); i++) begin
            r = '0; r.st = 3'd1; r.ir = (i == li(d) - 1); trace.push_back(r);
        end
        r = '0; r.st = 3'd2; trace.push_back(r);
        r = '0; r.st = 3'd3; r.alu = 1'b1; r.pc = !(rd || wr || wb); trace.push_back(r);
        if (rd || wr) begin
            for (int i = 0; i < ld(d); i++) begin
                r = '0; r.st = 3'd4; r.re = rd; r.we = wr && (i == 0);
                r.pc = !rd && (i == ld(d) - 1);
                trace.push_back(r);
            end
        end
        if (rd || (!wr && wb)) begin
            r = '0; r.st = 3'd5; r.rf = 1'b1; r.pc = 1'b1; trace.push_back(r);
        end
    endtask

    task automatic drive_cycle(input int d, input rec_t r, input bit last, input bit rd, input bit wr,
                               input bit rg, input bit cl, input bit halt_c, input bit run_c);
        if (r.st == 3'd2) begin
            rd_i[d] = rd; wr_i[d] = wr; rg_i[d] = rg; cl_i[d] = cl;
        end else begin
            rd_i[d] = 1'($urandom); wr_i[d] = 1'($urandom);
            rg_i[d] = 1'($urandom); cl_i[d] = 1'($urandom);
        end
        if (last) begin
            run_i[d] = run_c; halt_i[d] = halt_c;
        end else begin
            run_i[d] = 1'($urandom); halt_i[d] = 1'($urandom);
        end
    endtask

    // Runs one whole instruction starting at its first FETCH cycle; flags are garbage outside DECODE.
    task automatic exec_instr(input int d, input bit rd, input bit wr, input bit rg, input bit cl,
                              input bit halt_c, input bit run_c, input string name);
        logic [10:0] o, e;
        build_trace(d, rd, wr, rg || cl);
        for (int k = 0; k < trace.size(); k++) begin
            o = obs_vec(d);
            e = exp_vec(trace[k]);
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL %s dut%0d cycle %0d: got st/ir/alu/re/we/rf/pc/busy/halted=%b required %b",
                         name, d, k, o, e);
            end
            drive_cycle(d, trace[k], k == trace.size() - 1, rd, wr, rg, cl, halt_c, run_c);
            @(posedge clk); #1;
        end
        model_cyc[d] += trace.size();
        model_ins[d] += 1;
    endtask

    task automatic idle_cycles(input int d, input int n, input bit go);
        logic [10:0] o;
        for (int i = 0; i < n; i++) begin
            o = obs_vec(d);
            vectors++;
            if (o !== 11'd0) begin
                miscompares++;
                $display("FAIL idle dut%0d: got %b required %b", d, o, 11'd0);
            end
            run_i[d]  = (i == n - 1) ? go : 1'b0;
            halt_i[d] = 1'($urandom);
            rd_i[d]   = 1'($urandom);
            @(posedge clk); #1;
        end
    endtask

    task automatic check_counters(input int d, input string name);
        vectors++;
        if (ins_o[d] !== exp_cnt(model_ins[d])) begin
            miscompares++;
            $display("FAIL %s instr_count dut%0d: got %0d required %0d", name, d, ins_o[d], exp_cnt(model_ins[d]));
        end
        vectors++;
        if (cyc_o[d] !== exp_cnt(model_cyc[d])) begin
            miscompares++;
            $display("FAIL %s cycle_count dut%0d: got %0d required %0d", name, d, cyc_o[d], exp_cnt(model_cyc[d]));
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        run_i[0] = 1'b0; run_i[1] = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            model_cyc[d] = 0;
            model_ins[d] = 0;
        end
    endtask

    task automatic test_reset();
        logic [10:0] o;
        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            run_i[d] = 1'b1; halt_i[d] = 1'b0; rd_i[d] = 1'b0;
            wr_i[d] = 1'b0; rg_i[d] = 1'b0; cl_i[d] = 1'b0;
            model_cyc[d] = 0; model_ins[d] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            o = obs_vec(d);
            vectors++;
            if (o !== 11'd0) begin
                miscompares++;
                $display("FAIL reset outputs dut%0d: got %b required %b", d, o, 11'd0);
            end
            vectors++;
            if (cyc_o[d] !== '0 || ins_o[d] !== '0) begin
                miscompares++;
                $display("FAIL reset counters dut%0d: got %0d/%0d required 0/0", d, cyc_o[d], ins_o[d]);
            end
        end
        run_i[0] = 1'b0; run_i[1] = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_alu();
        idle_cycles(0, 1, 1'b1);
        exec_instr(0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "alu");
        exec_instr(0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "call");
        idle_cycles(0, 2, 1'b0);
        check_counters(0, "alu");
    endtask

    task automatic test_load_store();
        idle_cycles(0, 1, 1'b1);
        exec_instr(0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "load");
        idle_cycles(0, 1, 1'b0);
        idle_cycles(1, 1, 1'b1);
        exec_instr(1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "store");
        exec_instr(1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "load_store");
        exec_instr(1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "store_regwrite");
        idle_cycles(1, 1, 1'b0);
        check_counters(0, "load");
        check_counters(1, "store");
    endtask

    task automatic test_halt();
        logic [10:0] o, e;
        rec_t h;
        h = '0; h.st = 3'd6;
        e = exp_vec(h);
        idle_cycles(0, 1, 1'b1);
        exec_instr(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "branch_halt");
        for (int i = 0; i < 10; i++) begin
            o = obs_vec(0);
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL halt hold cycle %0d: got %b required %b", i, o, e);
            end
            run_i[0] = 1'b1; halt_i[0] = 1'($urandom);
            @(posedge clk); #1;
        end
        check_counters(0, "halt");
    endtask

    task automatic test_reset_mid();
        logic [10:0] o, e;
        int stop;
        pulse_reset();
        idle_cycles(1, 1, 1'b1);
        build_trace(1, 1'b0, 1'b1, 1'b0);
        stop = li(1) + 3;
        for (int k = 0; k <= stop; k++) begin
            o = obs_vec(1);
            e = exp_vec(trace[k]);
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL reset_mid dut1 cycle %0d: got %b required %b", k, o, e);
            end
            drive_cycle(1, trace[k], 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
            if (k != stop) begin
                @(posedge clk); #1;
            end
        end
        #2 reset = 1'b1;
        #1;
        o = obs_vec(1);
        vectors++;
        if (o !== 11'd0) begin
            miscompares++;
            $display("FAIL reset_mid immediate: got %b required %b", o, 11'd0);
        end
        run_i[1] = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        model_cyc[1] = 0; model_ins[1] = 0;
        model_cyc[0] = 0; model_ins[0] = 0;
        idle_cycles(1, 2, 1'b0);
        vectors++;
        if (ins_o[1] !== '0) begin
            miscompares++;
            $display("FAIL reset_mid instr_count: got %0d required 0", ins_o[1]);
        end
    endtask

    task automatic test_perf();
        pulse_reset();
        idle_cycles(0, 1, 1'b1);
        exec_instr(0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "perf0");
        exec_instr(0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "perf1");
        exec_instr(0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "perf2");
        idle_cycles(0, 1, 1'b0);
        vectors++;
        if (ins_o[0] !== exp_cnt(3)) begin
            miscompares++;
            $display("FAIL perf instr_count: got %0d required %0d", ins_o[0], exp_cnt(3));
        end
        vectors++;
        if (cyc_o[0] !== exp_cnt(12)) begin
            miscompares++;
            $display("FAIL perf cycle_count: got %0d required %0d", cyc_o[0], exp_cnt(12));
        end
    endtask

    task automatic test_random();
        bit rd, wr, rg, cl, rn;
        for (int d = 0; d < 2; d++) begin
            idle_cycles(d, 1, 1'b1);
            for (int n = 0; n < 25; n++) begin
                rd = 1'($urandom); wr = 1'($urandom);
                rg = 1'($urandom); cl = 1'($urandom);
                rn = (n == 24) ? 1'b0 : ($urandom_range(0, 3) != 0);
                exec_instr(d, rd, wr, rg, cl, 1'b0, rn, "random");
                if (!rn && n != 24) begin
                    idle_cycles(d, $urandom_range(1, 3), 1'b1);
                end
            end
            idle_cycles(d, 1, 1'b0);
            check_counters(d, "random");
        end
    endtask

    initial begin
        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            run_i[d] = 1'b0; halt_i[d] = 1'b0; rd_i[d] = 1'b0;
            wr_i[d] = 1'b0; rg_i[d] = 1'b0; cl_i[d] = 1'b0;
        end
        test_reset();
        test_alu();
        test_load_store();
        test_halt();
        test_reset_mid();
        test_perf();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/g9_multicycle_sequencer.md
# g9_multicycle_sequencer

Multi-cycle control sequencer for the G9 processor datapath. It steps each instruction through fetch, decode, execute, memory and write-back. It emits one-cycle enables for the instruction register, ALU result latch, data memory, register file and program counter, so the synchronous block-RAM instruction and data memories are used with their read latency honoured. It sits between the ControlUnit decode outputs and the storage elements of the datapath; it does not compute pc_next, it only decides when the PC commits.

## Interface
Parameters:
- size, 32: width of the performance counters.
- IMEM_LAT, 1: instruction memory read latency in cycles, legal range 1–7.
- DMEM_LAT, 1: data memory access latency in cycles, legal range 1–7.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high.
- run  in  1  start/continue enable; sampled in IDLE and at commit.
- halt_req  in  1  stop request; sampled at commit.
- mem_read  in  1  decoded load; from ControlUnit, valid from DECODE onward.
- mem_write  in  1  decoded store.
- reg_write  in  1  decoded register write-back.
- call  in  1  decoded Call; forces write-back.
- ir_en  out  1  instruction register load.
- alu_en  out  1  ALU result and flag latch.
- dmem_re  out  1  data memory read enable.
- dmem_we  out  1  data memory write enable.
- rf_we  out  1  register file write enable.
- pc_en  out  1  PC load of pc_next; exactly one pulse per retired instruction.
- state  out  3  current state encoding.
- busy  out  1  high in every state except IDLE and HALT.
- halted  out  1  high in HALT.
- cycle_count  out  size  active-cycle counter (see Configuration).
- instr_count  out  size  retired-instruction counter.

## Operation
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6. Encoding 7 is unreachable; if entered, the next state is IDLE.
- IDLE: all enables low. run=1 -> FETCH.
- FETCH: a wait counter counts IMEM_LAT cycles. ir_en pulses in the last FETCH cycle. Next state is DECODE.
- DECODE: one cycle. Latch the class flags mem_read, mem_write, reg_write|call into internal registers. Later states use only these latched flags. Next state is EXEC.
- EXEC: one cycle; alu_en=1.
  - Any memory flag -> MEM.
  - Else write-back flag -> WB.
  - Else commit (branch, Ret, nop).
- MEM: dmem_re held high for all DMEM_LAT cycles if a read is latched. dmem_we pulses only in the first MEM cycle if a write is latched.
  - Read latched -> WB.
  - Else commit.
  - Read and write both latched: both enables behave as above, then WB.
- WB: one cycle; rf_we=1, then commit.
- Commit: pc_en=1 in the cycle that leaves EXEC/MEM/WB. Next state:
  - HALT if halt_req=1.
  - Else IDLE if run=0.
  - Else FETCH.
  - halt_req has priority over run.
- HALT: all enables low; exits only on reset.
- Reset mid-instruction: the in-flight instruction is abandoned with no pc_en, rf_we or dmem_we. State goes to IDLE; wait counter and latched flags clear.
- Reset values: state=0, every enable=0, busy=0, halted=0, cycle_count=0, instr_count=0.
- At most one of ir_en, alu_en, rf_we is high in any cycle.

## Timing
- All outputs are registered-state decodes, valid in the same cycle as state.
- Cycles per instruction, with L_I=IMEM_LAT and L_D=DMEM_LAT:
  - ALU/Call: L_I+3.
  - Branch/Ret: L_I+2.
  - Store: L_I+2+L_D.
  - Load: L_I+3+L_D.
- FETCH follows the commit cycle with no bubble.
- run falling outside IDLE/commit has no effect until the next commit.
- The datapath must present mem_read/mem_write/reg_write/call stable from DECODE; input changes after DECODE are ignored.

## Configuration
- Macro G9_SEQ_PERF_EN.
- Defined:
  - cycle_count increments every cycle busy=1.
  - instr_count increments on every pc_en.
  - Both wrap modulo 2^size and clear on reset.
- Undefined: counter logic is omitted; both ports are tied to 0 and the port list is unchanged.

## Test plan
- Reset, run=1, ALU op (reg_write=1), IMEM_LAT=1 -> state 0,1,2,3,5; rf_we and pc_en in cycle 4; FETCH in cycle 5.
- Load (mem_read=1, reg_write=1), DMEM_LAT=2 -> dmem_re high 2 cycles, rf_we in the following cycle, pc_en once; 6 cycles total.
- Store with DMEM_LAT=3 -> dmem_we for exactly 1 cycle, dmem_re=0, no rf_we, pc_en on the third MEM cycle.
- Branch (all flags 0), with halt_req=1 at commit -> pc_en once, state=6, halted=1; held for 10 cycles with run=1, no enable asserted.
- Assert reset during MEM of a store after its dmem_we pulse -> state=0 immediately; pc_en and rf_we never assert; instr_count unchanged at 0.
- With G9_SEQ_PERF_EN defined, 3 ALU ops and IMEM_LAT=1, then run=0 -> instr_count=3, cycle_count=12. With the macro undefined -> both read 0.
